// File: rtl/tx_fsrc_seq_ctrl.sv
// Sequencer for the tx_fsrc hole-insertion datapath: seeds the lane accumulators,
// pulses accum_set, times start, counts beats and issues stop. Trigger gate: TX_FSRC_SEQ_TRIG_EN.
module tx_fsrc_seq_ctrl #(
  parameter int unsigned NUM_SAMPLES = 16,
  parameter int unsigned ACCUM_WIDTH = 64,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cfg_enable,
  input  logic [ACCUM_WIDTH-1:0]             cfg_seed_base,
  input  logic [ACCUM_WIDTH-1:0]             cfg_seed_step,
  input  logic [COUNT_WIDTH-1:0]             cfg_start_delay,
  input  logic [COUNT_WIDTH-1:0]             cfg_run_beats,
  input  logic                               arm,
  input  logic                               stop_req,
  input  logic                               trig,
  input  logic                               beat_valid,
  input  logic                               beat_ready,
  output logic                               enable,
  output logic                               start,
  output logic                               stop,
  output logic                               accum_set,
  output logic [NUM_SAMPLES*ACCUM_WIDTH-1:0] accum_set_val,
  output logic                               busy,
  output logic                               done,
  output logic                               aborted,
  output logic [COUNT_WIDTH-1:0]             beat_count,
  output logic [2:0]                         state
);

  localparam int unsigned IDX_W = $clog2(NUM_SAMPLES + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_TRIG = 3'd2,
    SET       = 3'd3,
    DELAY     = 3'd4,
    RUN       = 3'd5,
    STOP      = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q;
  logic [ACCUM_WIDTH-1:0] seed_q, step_q;
  logic [COUNT_WIDTH-1:0] delay_q, run_beats_q;
  logic [COUNT_WIDTH-1:0] count_inc;
  logic                   beat_fire, hit_len;
  logic                   abort, arm_go, lane_wr;

`ifndef TX_FSRC_SEQ_TRIG_EN
  logic trig_unused;
  assign trig_unused = trig;
`endif

  assign beat_fire = beat_valid & beat_ready;
  assign count_inc = (&beat_count) ? beat_count : beat_count + COUNT_WIDTH'(1);
  assign hit_len   = (run_beats_q != '0) && beat_fire && (count_inc == run_beats_q);
  assign state     = state_q;

  // LOAD spends one extra cycle at idx==NUM_SAMPLES so the last lane is settled
  // before SET; accum_set then coincides with the SET state.
  always_comb begin
    state_d = state_q;
    arm_go  = 1'b0;
    lane_wr = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm && cfg_enable) begin
          arm_go  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (idx_q == IDX_W'(NUM_SAMPLES)) begin
`ifdef TX_FSRC_SEQ_TRIG_EN
          state_d = WAIT_TRIG;
`else
          state_d = SET;
`endif
        end else begin
          lane_wr = 1'b1;
        end
      end
`ifdef TX_FSRC_SEQ_TRIG_EN
      WAIT_TRIG: begin
        if (trig) state_d = SET;
      end
`endif
      SET:   state_d = (delay_q == '0) ? RUN : DELAY;
      DELAY: begin
        if (delay_q == COUNT_WIDTH'(1)) state_d = RUN;
      end
      RUN: begin
        if (hit_len || stop_req) state_d = STOP;
      end
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // STOP is already finishing, so it is exempt from abort.
    if (state_q != IDLE && state_q != STOP && !cfg_enable) begin
      abort = 1'b1;
    end else if ((state_q == LOAD || state_q == WAIT_TRIG || state_q == SET ||
                  state_q == DELAY) && stop_req) begin
      abort = 1'b1;
    end

    if (abort) begin
      state_d = IDLE;
      lane_wr = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      seed_q        <= '0;
      step_q        <= '0;
      delay_q       <= '0;
      run_beats_q   <= '0;
      enable        <= 1'b0;
      start         <= 1'b0;
      stop          <= 1'b0;
      accum_set     <= 1'b0;
      accum_set_val <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      beat_count    <= '0;
    end else begin
      state_q   <= state_d;
      enable    <= cfg_enable;
      start     <= (state_d == RUN) && (state_q != RUN);
      stop      <= abort || (state_d == STOP);
      done      <= (state_d == STOP);
      aborted   <= abort;
      accum_set <= (state_d == SET);
      busy      <= (state_d != IDLE);

      if (arm_go) begin
        seed_q      <= cfg_seed_base;
        step_q      <= cfg_seed_step;
        delay_q     <= cfg_start_delay;
        run_beats_q <= cfg_run_beats;
        beat_count  <= '0;
        idx_q       <= '0;
      end

      if (lane_wr) begin
        for (int unsigned i = 0; i < NUM_SAMPLES; i++) begin
          if (idx_q == IDX_W'(i)) accum_set_val[i*ACCUM_WIDTH +: ACCUM_WIDTH] <= seed_q;
        end
        seed_q <= seed_q + step_q;
        idx_q  <= idx_q + IDX_W'(1);
      end

      if (state_q == DELAY) delay_q <= delay_q - COUNT_WIDTH'(1);
      if (state_q == RUN && beat_fire) beat_count <= count_inc;
    end
  end

endmodule
